// File: rtl/multicycle_ctrl_if.sv
// Control-unit bundle between the multicycle RV32I datapath and its controller.
// The controller uses the master view; the datapath (or a bench) uses the slave view.
interface multicycle_ctrl_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic [1:0] immsrc;
  logic [1:0] alusrca;
  logic [1:0] alusrcb;
  logic [1:0] resultsrc;
  logic       adrsrc;
  logic [2:0] alucontrol;
  logic       irwrite;
  logic       pcwrite;
  logic       regwrite;
  logic       memwrite;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  op, funct3, funct7b5, zero,
    output immsrc, alusrca, alusrcb, resultsrc, adrsrc, alucontrol,
           irwrite, pcwrite, regwrite, memwrite, illegal, state
  );

  modport slave (
    output op, funct3, funct7b5, zero,
    input  immsrc, alusrca, alusrcb, resultsrc, adrsrc, alucontrol,
           irwrite, pcwrite, regwrite, memwrite, illegal, state
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control unit: Moore main FSM plus combinational immediate
// and ALU decoders, covering lw, sw, R-type, I-type ALU, beq and jal.
module multicycle_ctrl (
  input  logic                  clk,
  input  logic                  reset,
  multicycle_ctrl_if.master     bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  state_t     r_state;
  state_t     w_next;
  logic [1:0] w_aluop;
  logic [1:0] w_alusrca;
  logic [1:0] w_alusrcb;
  logic [1:0] w_resultsrc;
  logic       w_adrsrc;
  logic       w_irwrite;
  logic       w_pcupdate;
  logic       w_branch;
  logic       w_regwrite;
  logic       w_memwrite;
  logic       w_illegal;
  logic [2:0] w_alucontrol;
  logic [1:0] w_immsrc;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its inputs, independent of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next      = S_FETCH;
    w_aluop     = 2'b00;
    w_alusrca   = 2'b00;
    w_alusrcb   = 2'b00;
    w_resultsrc = 2'b00;
    w_adrsrc    = 1'b0;
    w_irwrite   = 1'b0;
    w_pcupdate  = 1'b0;
    w_branch    = 1'b0;
    w_regwrite  = 1'b0;
    w_memwrite  = 1'b0;
    w_illegal   = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_next      = S_DECODE;
        w_irwrite   = 1'b1;
        w_alusrcb   = 2'b10;
        w_resultsrc = 2'b10;
        w_pcupdate  = 1'b1;
      end
      S_DECODE: begin
        // ALU forms OldPC + immext here so BEQ can load the target from ALUOut.
        w_alusrca = 2'b01;
        w_alusrcb = 2'b01;
        case (bus.op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_R:         w_next = S_EXECR;
          OP_I:         w_next = S_EXECI;
          OP_JAL:       w_next = S_JAL;
          OP_BEQ:       w_next = S_BEQ;
          default: begin
            w_next    = S_FETCH;
            w_illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        w_alusrca = 2'b10;
        w_alusrcb = 2'b01;
        w_next    = (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        w_adrsrc = 1'b1;
        w_next   = S_MEMWB;
      end
      S_MEMWB: begin
        w_resultsrc = 2'b01;
        w_regwrite  = 1'b1;
      end
      S_MEMWRITE: begin
        w_adrsrc   = 1'b1;
        w_memwrite = 1'b1;
      end
      S_EXECR: begin
        w_alusrca = 2'b10;
        w_aluop   = 2'b10;
        w_next    = S_ALUWB;
      end
      S_EXECI: begin
        w_alusrca = 2'b10;
        w_alusrcb = 2'b01;
        w_aluop   = 2'b10;
        w_next    = S_ALUWB;
      end
      S_ALUWB: w_regwrite = 1'b1;
      S_JAL: begin
        // ALUOut still holds the jump target from DECODE; ALU makes PC+4 for rd.
        w_alusrca  = 2'b01;
        w_alusrcb  = 2'b10;
        w_pcupdate = 1'b1;
        w_next     = S_ALUWB;
      end
      S_BEQ: begin
        w_alusrca = 2'b10;
        w_aluop   = 2'b01;
        w_branch  = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase
  end

  always_comb begin
    case (bus.op)
      OP_SW:   w_immsrc = 2'b01;
      OP_BEQ:  w_immsrc = 2'b10;
      OP_JAL:  w_immsrc = 2'b11;
      default: w_immsrc = 2'b00;
    endcase
  end

  always_comb begin
    w_alucontrol = ALU_ADD;
    if (w_aluop == 2'b01) begin
      w_alucontrol = ALU_SUB;
    end else if (w_aluop == 2'b10) begin
      case (bus.funct3)
        3'b000:  w_alucontrol = (bus.op[5] & bus.funct7b5) ? ALU_SUB : ALU_ADD;
        3'b010:  w_alucontrol = ALU_SLT;
        3'b110:  w_alucontrol = ALU_OR;
        3'b111:  w_alucontrol = ALU_AND;
        default: w_alucontrol = ALU_ADD;
      endcase
    end
  end

  // Enables are gated directly by reset so they drop without waiting for a clock.
  assign bus.irwrite    = w_irwrite & ~reset;
  assign bus.pcwrite    = (w_pcupdate | (w_branch & bus.zero)) & ~reset;
  assign bus.regwrite   = w_regwrite & ~reset;
  assign bus.memwrite   = w_memwrite & ~reset;
  assign bus.illegal    = w_illegal & ~reset;
  assign bus.immsrc     = w_immsrc;
  assign bus.alusrca    = w_alusrca;
  assign bus.alusrcb    = w_alusrcb;
  assign bus.resultsrc  = w_resultsrc;
  assign bus.adrsrc     = w_adrsrc;
  assign bus.alucontrol = w_alucontrol;
  assign bus.state      = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed instruction scenarios plus
// randomized instruction streams checked against a per-class reference model.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic [3:0] state;
    logic [1:0] immsrc;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] resultsrc;
    logic       adrsrc;
    logic [2:0] alucontrol;
    logic       irwrite;
    logic       pcwrite;
    logic       regwrite;
    logic       memwrite;
    logic       illegal;
  } ctrl_t;

  typedef int     seq_t[$];
  typedef ctrl_t  cap_t[$];

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  logic  clk;
  logic  reset;
  int    n_checks;
  int    n_fail;
  ctrl_t obs;

  multicycle_ctrl_if bus ();

  multicycle_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  assign obs = {bus.state, bus.immsrc, bus.alusrca, bus.alusrcb, bus.resultsrc,
                bus.adrsrc, bus.alucontrol, bus.irwrite, bus.pcwrite,
                bus.regwrite, bus.memwrite, bus.illegal};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1, "watchdog");
  end

  // State walk per instruction class, straight from the cycles-per-instruction rules.
  function automatic seq_t model_seq(input logic [6:0] op);
    case (op)
      OP_LW:   return '{0, 1, 2, 3, 4};
      OP_SW:   return '{0, 1, 2, 5};
      OP_R:    return '{0, 1, 6, 7};
      OP_I:    return '{0, 1, 8, 7};
      OP_JAL:  return '{0, 1, 9, 7};
      OP_BEQ:  return '{0, 1, 10};
      default: return '{0, 1};
    endcase
  endfunction

  // Expected outputs for one cycle, from the per-state output table.
  function automatic ctrl_t model_out(input int st, input logic [6:0] op,
                                      input logic [2:0] f3, input logic f7,
                                      input logic z, input logic rst);
    ctrl_t      e;
    logic [1:0] aluop;
    e     = '0;
    aluop = 2'b00;
    e.state = st[3:0];
    case (op)
      OP_SW:   e.immsrc = 2'b01;
      OP_BEQ:  e.immsrc = 2'b10;
      OP_JAL:  e.immsrc = 2'b11;
      default: e.immsrc = 2'b00;
    endcase
    case (st)
      0:  begin e.irwrite = 1; e.alusrcb = 2'b10; e.resultsrc = 2'b10; e.pcwrite = 1; end
      1:  begin e.alusrca = 2'b01; e.alusrcb = 2'b01; e.illegal = (model_seq(op).size() == 2); end
      2:  begin e.alusrca = 2'b10; e.alusrcb = 2'b01; end
      3:  e.adrsrc = 1;
      4:  begin e.resultsrc = 2'b01; e.regwrite = 1; end
      5:  begin e.adrsrc = 1; e.memwrite = 1; end
      6:  begin e.alusrca = 2'b10; aluop = 2'b10; end
      7:  e.regwrite = 1;
      8:  begin e.alusrca = 2'b10; e.alusrcb = 2'b01; aluop = 2'b10; end
      9:  begin e.alusrca = 2'b01; e.alusrcb = 2'b10; e.pcwrite = 1; end
      10: begin e.alusrca = 2'b10; aluop = 2'b01; e.pcwrite = z; end
      default: ;
    endcase
    if (aluop == 2'b01) e.alucontrol = 3'b001;
    else if (aluop == 2'b10) begin
      if (f3 == 3'b000)      e.alucontrol = (op[5] && f7) ? 3'b001 : 3'b000;
      else if (f3 == 3'b010) e.alucontrol = 3'b101;
      else if (f3 == 3'b110) e.alucontrol = 3'b011;
      else if (f3 == 3'b111) e.alucontrol = 3'b010;
    end
    if (rst) begin
      e.irwrite = 0; e.pcwrite = 0; e.regwrite = 0; e.memwrite = 0; e.illegal = 0;
    end
    return e;
  endfunction

  // Runs one instruction from FETCH, compares every cycle against the model and
  // returns the observed outputs so callers can add scenario-specific checks.
  task automatic test_instr(input string name, input logic [6:0] op, input logic [2:0] f3,
                            input logic f7, input logic z, output cap_t got);
    seq_t  seq;
    ctrl_t exp;
    got = {};
    seq = model_seq(op);
    bus.op = op; bus.funct3 = f3; bus.funct7b5 = f7; bus.zero = z;
    #1;
    foreach (seq[k]) begin
      exp = model_out(seq[k], op, f3, f7, z, 1'b0);
      got.push_back(obs);
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL %s cycle %0d: got %h want %h (state got %0d want %0d)",
                 name, k, obs, exp, obs.state, seq[k]);
      end
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (obs.state !== 4'd0) begin
      n_fail++;
      $display("FAIL %s return_to_fetch: got state %0d want 0", name, obs.state);
    end
  endtask

  task automatic test_reset();
    ctrl_t exp;
    reset = 1'b1;
    bus.op = OP_LW; bus.funct3 = 3'b010; bus.funct7b5 = 1'b0; bus.zero = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    exp = model_out(0, OP_LW, 3'b010, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h want %h", obs, exp);
    end
    reset = 1'b0;
  endtask

  task automatic test_lw();
    cap_t got;
    test_instr("lw", OP_LW, 3'b010, 1'b0, 1'b0, got);
    n_checks++;
    if (got[3].adrsrc !== 1'b1 || got[4].regwrite !== 1'b1) begin
      n_fail++;
      $display("FAIL lw_memread_wb: got adrsrc=%b regwrite=%b want 1 1",
               got[3].adrsrc, got[4].regwrite);
    end
  endtask

  task automatic test_sw();
    cap_t got;
    test_instr("sw", OP_SW, 3'b010, 1'b0, 1'b0, got);
    n_checks++;
    if (got[3].memwrite !== 1'b1 || got[3].immsrc !== 2'b01) begin
      n_fail++;
      $display("FAIL sw_memwrite: got memwrite=%b immsrc=%b want 1 01",
               got[3].memwrite, got[3].immsrc);
    end
  endtask

  task automatic test_rtype();
    cap_t       got;
    logic [2:0] want[3];
    logic [2:0] f3s[3];
    logic       f7s[3];
    f3s = '{3'b000, 3'b000, 3'b110};
    f7s = '{1'b1, 1'b0, 1'b0};
    want = '{3'b001, 3'b000, 3'b011};
    for (int i = 0; i < 3; i++) begin
      test_instr("rtype", OP_R, f3s[i], f7s[i], 1'b0, got);
      n_checks++;
      if (got[2].alucontrol !== want[i]) begin
        n_fail++;
        $display("FAIL rtype_alucontrol[%0d]: got %b want %b", i, got[2].alucontrol, want[i]);
      end
    end
  endtask

  task automatic test_beq();
    cap_t got;
    for (int z = 1; z >= 0; z--) begin
      test_instr("beq", OP_BEQ, 3'b000, 1'b0, z[0], got);
      n_checks++;
      if (got[2].pcwrite !== z[0] || got[0].pcwrite !== 1'b1 || got[2].alucontrol !== 3'b001) begin
        n_fail++;
        $display("FAIL beq_pcwrite zero=%0d: got beq=%b fetch=%b alu=%b want %0d 1 001",
                 z, got[2].pcwrite, got[0].pcwrite, got[2].alucontrol, z);
      end
    end
  endtask

  task automatic test_jal();
    cap_t got;
    test_instr("jal", OP_JAL, 3'b000, 1'b0, 1'b0, got);
    n_checks++;
    if (got[2].pcwrite !== 1'b1 || got[2].alusrcb !== 2'b10 ||
        got[3].regwrite !== 1'b1 || got[2].immsrc !== 2'b11) begin
      n_fail++;
      $display("FAIL jal_outputs: got pcwrite=%b alusrcb=%b regwrite=%b immsrc=%b want 1 10 1 11",
               got[2].pcwrite, got[2].alusrcb, got[3].regwrite, got[2].immsrc);
    end
  endtask

  task automatic test_illegal();
    cap_t got;
    test_instr("illegal", 7'b1111111, 3'b000, 1'b0, 1'b0, got);
    n_checks++;
    if (got[1].illegal !== 1'b1 || got[1].regwrite !== 1'b0 || got[1].memwrite !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_decode: got illegal=%b regwrite=%b memwrite=%b want 1 0 0",
               got[1].illegal, got[1].regwrite, got[1].memwrite);
    end
  endtask

  task automatic test_reset_mid();
    ctrl_t exp;
    bus.op = OP_SW; bus.funct3 = 3'b010; bus.funct7b5 = 1'b0; bus.zero = 1'b0;
    #1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (obs.state !== 4'd5 || obs.memwrite !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_pre: got state=%0d memwrite=%b want 5 1", obs.state, obs.memwrite);
    end
    #2 reset = 1'b1;
    #1;
    exp = model_out(0, OP_SW, 3'b010, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL reset_mid_async: got %h want %h", obs, exp);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL reset_mid_held: got %h want %h", obs, exp);
    end
    reset = 1'b0;
  endtask

  task automatic test_back_to_back();
    cap_t       got;
    logic [6:0] ops[6];
    logic [6:0] op;
    ops = '{OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ};
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 5) == 0) op = 7'($urandom);
      else                           op = ops[$urandom_range(0, 5)];
      test_instr("random", op, 3'($urandom), 1'($urandom), 1'($urandom), got);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_lw();
    test_sw();
    test_rtype();
    test_beq();
    test_jal();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
